// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants for the UART receive path: frame-state
//               encoding, the legal oversampling factors and the default
//               payload width.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int DATA_WIDTH_DEFAULT = 8;

   // Oversampling factors the receiver accepts; anything else runs at 8.
   localparam int PRESCALE_8  = 8;
   localparam int PRESCALE_16 = 16;
   localparam int PRESCALE_32 = 32;

   // Frame-state encoding.
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      START  = ST_START,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP   = ST_STOP
   } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sampler
// Description : Per-bit edge counter and mid-bit sampler. With
//               UART_RX_MAJORITY_VOTE_EN defined, three samples around the
//               bit centre are voted; otherwise a single centre sample is
//               used. Emits bit_value with a one-cycle bit_ready strobe and
//               flags the last edge of each bit period with bit_end.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sampler #(
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      active,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic                      serial_data_in,
   output logic                      bit_value,
   output logic                      bit_ready,
   output logic                      bit_end
);

   localparam logic [PRESCALE_WIDTH-1:0] EDGE_ONE = PRESCALE_WIDTH'(1);

   logic [PRESCALE_WIDTH-1:0] edge_count;
   logic [PRESCALE_WIDTH-1:0] half;
   logic [PRESCALE_WIDTH-1:0] last_edge;

   assign half      = prescale >> 1;
   assign last_edge = prescale - EDGE_ONE;
   assign bit_end   = active && (edge_count == last_edge);

   // Edge counter: the start-detect cycle is edge 0, so the next cycle is 1.
   always_ff @(posedge clk) begin
      if (!reset) begin
         edge_count <= '0;
      end else if (start) begin
         edge_count <= EDGE_ONE;
      end else if (active) begin
         edge_count <= (edge_count == last_edge) ? '0 : edge_count + EDGE_ONE;
      end else begin
         edge_count <= '0;
      end
   end

`ifdef UART_RX_MAJORITY_VOTE_EN
   logic sample_0;
   logic sample_1;
   logic sample_2;

   // Capture three samples around the bit centre; strobe after the last one.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sample_0  <= 1'b0;
         sample_1  <= 1'b0;
         sample_2  <= 1'b0;
         bit_ready <= 1'b0;
      end else begin
         bit_ready <= 1'b0;
         if (active) begin
            if (edge_count == half - EDGE_ONE) sample_0 <= serial_data_in;
            if (edge_count == half)            sample_1 <= serial_data_in;
            if (edge_count == half + EDGE_ONE) begin
               sample_2  <= serial_data_in;
               bit_ready <= 1'b1;
            end
         end
      end
   end

   assign bit_value = (sample_0 & sample_1) | (sample_0 & sample_2) | (sample_1 & sample_2);
`else
   logic sample_mid;

   // Capture one sample at the bit centre; strobe in the following cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sample_mid <= 1'b0;
         bit_ready  <= 1'b0;
      end else begin
         bit_ready <= 1'b0;
         if (active && (edge_count == half)) begin
            sample_mid <= serial_data_in;
            bit_ready  <= 1'b1;
         end
      end
   end

   assign bit_value = sample_mid;
`endif

endmodule
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : UART receive FSM. Detects the start edge, latches the frame
//               configuration, shifts the payload LSB-first, checks optional
//               parity and the stop bit, and pulses exactly one of
//               data_valid / parity_error / framing_error per frame.
//               Optional build macro: UART_RX_MAJORITY_VOTE_EN (3-sample
//               majority vote per bit instead of a single centre sample).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic                      parity_enable,
   input  logic                      parity_type,
   input  logic                      serial_data_in,
   output logic [DATA_WIDTH-1:0]     parallel_data,
   output logic                      data_valid,
   output logic                      parity_error,
   output logic                      framing_error,
   output logic                      busy
);

   localparam int BIT_COUNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BIT_COUNT_WIDTH-1:0] LAST_DATA_BIT = BIT_COUNT_WIDTH'(DATA_WIDTH - 1);

   rx_state_t                  state;
   logic [PRESCALE_WIDTH-1:0]  prescale_q;
   logic                       parity_enable_q;
   logic                       parity_type_q;
   logic [BIT_COUNT_WIDTH-1:0] bit_count;
   logic [DATA_WIDTH-1:0]      shift_reg;
   logic                       parity_bad;
   logic [PRESCALE_WIDTH-1:0]  prescale_legal;
   logic                       start_detect;
   logic                       bit_value;
   logic                       bit_ready;
   logic                       bit_end;

   assign start_detect = (state == IDLE) && !serial_data_in;

   // Force any unsupported oversampling factor back to 8.
   always_comb begin
      prescale_legal = PRESCALE_WIDTH'(PRESCALE_8);
      if ((prescale == PRESCALE_WIDTH'(PRESCALE_16)) ||
          (prescale == PRESCALE_WIDTH'(PRESCALE_32))) begin
         prescale_legal = prescale;
      end
   end

   uart_rx_sampler #(
      .PRESCALE_WIDTH (PRESCALE_WIDTH)
   ) u_sampler (
      .clk            (clk),
      .reset          (reset),
      .start          (start_detect),
      .active         (busy),
      .prescale       (prescale_q),
      .serial_data_in (serial_data_in),
      .bit_value      (bit_value),
      .bit_ready      (bit_ready),
      .bit_end        (bit_end)
   );

   // Frame FSM with registered result pulses, payload and busy flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state           <= IDLE;
         prescale_q      <= PRESCALE_WIDTH'(PRESCALE_8);
         parity_enable_q <= 1'b0;
         parity_type_q   <= 1'b0;
         bit_count       <= '0;
         shift_reg       <= '0;
         parity_bad      <= 1'b0;
         parallel_data   <= '0;
         data_valid      <= 1'b0;
         parity_error    <= 1'b0;
         framing_error   <= 1'b0;
         busy            <= 1'b0;
      end else begin
         data_valid    <= 1'b0;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
         case (state)
            IDLE: begin
               if (!serial_data_in) begin
                  state           <= START;
                  busy            <= 1'b1;
                  prescale_q      <= prescale_legal;
                  parity_enable_q <= parity_enable;
                  parity_type_q   <= parity_type;
                  bit_count       <= '0;
                  parity_bad      <= 1'b0;
               end
            end
            START: begin
               // A start bit that votes high was only a glitch.
               if (bit_ready && bit_value) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (bit_end) begin
                  state <= DATA;
               end
            end
            DATA: begin
               if (bit_ready) begin
                  shift_reg <= {bit_value, shift_reg[DATA_WIDTH-1:1]};
               end
               if (bit_end) begin
                  if (bit_count == LAST_DATA_BIT) begin
                     bit_count <= '0;
                     state     <= parity_enable_q ? PARITY : STOP;
                  end else begin
                     bit_count <= bit_count + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (bit_ready) begin
                  parity_bad <= bit_value != (parity_type_q ? ~^shift_reg : ^shift_reg);
               end
               if (bit_end) begin
                  state <= STOP;
               end
            end
            STOP: begin
               // Finish on the stop-bit decision so a new start can follow promptly.
               if (bit_ready) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  if (!bit_value) begin
                     framing_error <= 1'b1;
                  end else if (parity_bad) begin
                     parity_error <= 1'b1;
                  end else begin
                     data_valid    <= 1'b1;
                     parallel_data <= shift_reg;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Directed self-checking bench for uart_receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

`ifdef UART_RX_MAJORITY_VOTE_EN
   localparam int RES_OFF = 3;
`else
   localparam int RES_OFF = 2;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] prescale;
   logic       parity_enable;
   logic       parity_type;
   logic       serial_data_in;
   logic [7:0] parallel_data;
   logic       data_valid;
   logic       parity_error;
   logic       framing_error;
   logic       busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int         dv_cnt = 0, pe_cnt = 0, fe_cnt = 0, busy_bad = 0;
   int         dv_last_cyc = 0, dv_prev_cyc = 0, pe_last_cyc = 0, fe_last_cyc = 0;
   logic [7:0] dv_last_data = 8'h00, dv_prev_data = 8'h00;

   uart_receiver dut (
      .clk            (clk),
      .reset          (reset),
      .prescale       (prescale),
      .parity_enable  (parity_enable),
      .parity_type    (parity_type),
      .serial_data_in (serial_data_in),
      .parallel_data  (parallel_data),
      .data_valid     (data_valid),
      .parity_error   (parity_error),
      .framing_error  (framing_error),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (data_valid) begin
         dv_cnt       = dv_cnt + 1;
         dv_prev_cyc  = dv_last_cyc;
         dv_last_cyc  = cyc;
         dv_prev_data = dv_last_data;
         dv_last_data = parallel_data;
      end
      if (parity_error) begin
         pe_cnt      = pe_cnt + 1;
         pe_last_cyc = cyc;
      end
      if (framing_error) begin
         fe_cnt      = fe_cnt + 1;
         fe_last_cyc = cyc;
      end
      if ((data_valid || parity_error || framing_error) && busy) busy_bad = busy_bad + 1;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives one frame; config inputs are scrambled mid-frame and restored for the stop bit.
   task automatic send_frame(input logic [7:0] data, input int p, input logic pen,
                             input logic ptype, input logic pbit, input logic stop,
                             output int t0, output logic busy1);
      prescale       = 6'(p);
      parity_enable  = pen;
      parity_type    = ptype;
      serial_data_in = 1'b0;
      t0             = cyc;
      wait_cycles(1);
      busy1 = busy;
      wait_cycles(p - 1);
      prescale      = (p == 8) ? 6'd16 : 6'd8;
      parity_enable = ~pen;
      parity_type   = ~ptype;
      for (int i = 0; i < 8; i++) begin
         serial_data_in = data[i];
         wait_cycles(p);
      end
      if (pen) begin
         serial_data_in = pbit;
         wait_cycles(p);
      end
      prescale       = 6'(p);
      parity_enable  = pen;
      parity_type    = ptype;
      serial_data_in = stop;
      wait_cycles(p);
      serial_data_in = 1'b1;
   endtask

   task automatic test_reset;
      reset          = 1'b0;
      serial_data_in = 1'b1;
      prescale       = 6'd8;
      parity_enable  = 1'b0;
      parity_type    = 1'b0;
      wait_cycles(3);
      total++; if (parallel_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h expected 00", parallel_data); end
      total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_dv: got %b expected 0", data_valid); end
      total++; if (parity_error !== 1'b0) begin bad++; $display("FAIL reset_pe: got %b expected 0", parity_error); end
      total++; if (framing_error !== 1'b0) begin bad++; $display("FAIL reset_fe: got %b expected 0", framing_error); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
      reset = 1'b1;
      wait_cycles(4);
   endtask

   task automatic test_parity_good;
      int t0, dv0, pe0, fe0; logic b1;
      dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
      send_frame(8'hE6, 8, 1'b1, 1'b0, 1'b1, 1'b1, t0, b1);
      wait_cycles(4);
      total++; if (b1 !== 1'b1) begin bad++; $display("FAIL good_busy_t1: got %b expected 1", b1); end
      total++; if (dv_cnt - dv0 != 1) begin bad++; $display("FAIL good_dv_count: got %0d expected 1", dv_cnt - dv0); end
      total++; if (pe_cnt - pe0 != 0 || fe_cnt - fe0 != 0) begin bad++; $display("FAIL good_errors: got pe=%0d fe=%0d expected 0 0", pe_cnt - pe0, fe_cnt - fe0); end
      total++; if (dv_last_data !== 8'hE6) begin bad++; $display("FAIL good_data: got %h expected e6", dv_last_data); end
      total++; if (dv_last_cyc != t0 + 10*8 + 4 + RES_OFF) begin bad++; $display("FAIL good_cycle: got %0d expected %0d", dv_last_cyc, t0 + 10*8 + 4 + RES_OFF); end
   endtask

   task automatic test_parity_error;
      int t0, dv0, pe0, fe0; logic b1;
      dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
      send_frame(8'hFF, 16, 1'b1, 1'b1, 1'b0, 1'b1, t0, b1);
      wait_cycles(4);
      total++; if (pe_cnt - pe0 != 1) begin bad++; $display("FAIL perr_count: got %0d expected 1", pe_cnt - pe0); end
      total++; if (dv_cnt - dv0 != 0 || fe_cnt - fe0 != 0) begin bad++; $display("FAIL perr_others: got dv=%0d fe=%0d expected 0 0", dv_cnt - dv0, fe_cnt - fe0); end
      total++; if (parallel_data !== 8'hE6) begin bad++; $display("FAIL perr_hold: got %h expected e6", parallel_data); end
      total++; if (pe_last_cyc != t0 + 10*16 + 8 + RES_OFF) begin bad++; $display("FAIL perr_cycle: got %0d expected %0d", pe_last_cyc, t0 + 10*16 + 8 + RES_OFF); end
   endtask

   task automatic test_framing;
      int t0, dv0, pe0, fe0; logic b1;
      dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
      send_frame(8'hF4, 32, 1'b0, 1'b0, 1'b0, 1'b0, t0, b1);
      wait_cycles(64);
      total++; if (fe_cnt - fe0 != 1) begin bad++; $display("FAIL ferr_count: got %0d expected 1", fe_cnt - fe0); end
      total++; if (dv_cnt - dv0 != 0 || pe_cnt - pe0 != 0) begin bad++; $display("FAIL ferr_others: got dv=%0d pe=%0d expected 0 0", dv_cnt - dv0, pe_cnt - pe0); end
      total++; if (fe_last_cyc != t0 + 9*32 + 16 + RES_OFF) begin bad++; $display("FAIL ferr_cycle: got %0d expected %0d", fe_last_cyc, t0 + 9*32 + 16 + RES_OFF); end
      dv0 = dv_cnt;
      send_frame(8'hF4, 32, 1'b0, 1'b0, 1'b0, 1'b1, t0, b1);
      wait_cycles(4);
      total++; if (dv_cnt - dv0 != 1) begin bad++; $display("FAIL ferr_next_dv: got %0d expected 1", dv_cnt - dv0); end
      total++; if (dv_last_data !== 8'hF4) begin bad++; $display("FAIL ferr_next_data: got %h expected f4", dv_last_data); end
   endtask

   task automatic test_glitch;
      int t0, dv0, pe0, fe0;
      dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
      prescale       = 6'd16;
      parity_enable  = 1'b0;
      serial_data_in = 1'b0;
      t0 = cyc;
      wait_cycles(3);
      serial_data_in = 1'b1;
      wait_cycles(2);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_hi: got %b expected 1 at cycle %0d", busy, cyc - t0); end
      wait_cycles(9);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_lo: got %b expected 0 at cycle %0d", busy, cyc - t0); end
      wait_cycles(20);
      total++; if (dv_cnt != dv0 || pe_cnt != pe0 || fe_cnt != fe0) begin bad++; $display("FAIL glitch_pulses: got dv=%0d pe=%0d fe=%0d expected none", dv_cnt - dv0, pe_cnt - pe0, fe_cnt - fe0); end
   endtask

   task automatic test_back_to_back;
      int t0a, t0b, dv0; logic b1;
      dv0 = dv_cnt;
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, t0a, b1);
      send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b0, 1'b1, t0b, b1);
      wait_cycles(4);
      total++; if (dv_cnt - dv0 != 2) begin bad++; $display("FAIL b2b_count: got %0d expected 2", dv_cnt - dv0); end
      total++; if (dv_prev_data !== 8'h55 || dv_last_data !== 8'hAA) begin bad++; $display("FAIL b2b_data: got %h %h expected 55 aa", dv_prev_data, dv_last_data); end
      total++; if (dv_last_cyc - dv_prev_cyc != 80) begin bad++; $display("FAIL b2b_spacing: got %0d expected 80", dv_last_cyc - dv_prev_cyc); end
      total++; if (dv_prev_cyc != t0a + 9*8 + 4 + RES_OFF) begin bad++; $display("FAIL b2b_cycle: got %0d expected %0d", dv_prev_cyc, t0a + 9*8 + 4 + RES_OFF); end
   endtask

   task automatic test_reset_mid_frame;
      int t0, dv0, pe0, fe0; logic b1;
      logic [7:0] d;
      d = 8'h3C;
      dv0 = dv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
      prescale       = 6'd8;
      parity_enable  = 1'b0;
      serial_data_in = 1'b0;
      wait_cycles(8);
      for (int i = 0; i < 4; i++) begin
         serial_data_in = d[i];
         wait_cycles(8);
      end
      serial_data_in = d[4];
      wait_cycles(3);
      reset = 1'b0;
      wait_cycles(1);
      reset          = 1'b1;
      serial_data_in = 1'b1;
      total++; if (parallel_data !== 8'h00) begin bad++; $display("FAIL rmid_data: got %h expected 00", parallel_data); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b expected 0", busy); end
      total++; if ({data_valid, parity_error, framing_error} !== 3'b000) begin bad++; $display("FAIL rmid_pulses: got %b expected 000", {data_valid, parity_error, framing_error}); end
      wait_cycles(40);
      total++; if (dv_cnt != dv0 || pe_cnt != pe0 || fe_cnt != fe0) begin bad++; $display("FAIL rmid_no_pulse: got dv=%0d pe=%0d fe=%0d expected none", dv_cnt - dv0, pe_cnt - pe0, fe_cnt - fe0); end
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, t0, b1);
      wait_cycles(4);
      total++; if (dv_cnt - dv0 != 1 || dv_last_data !== 8'h3C) begin bad++; $display("FAIL rmid_next: got count=%0d data=%h expected 1 3c", dv_cnt - dv0, dv_last_data); end
      total++; if (busy_bad != 0) begin bad++; $display("FAIL busy_in_pulse: got %0d expected 0", busy_bad); end
   endtask

   initial begin
      test_reset();
      test_parity_good();
      test_parity_error();
      test_framing();
      test_glitch();
      test_back_to_back();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
# uart_receiver

Receive-side UART: recovers 8-bit frames from the serial line driven by the team's UART transmitter, or by an external device on the same link. Supported frame format: start bit, data LSB-first, optional even/odd parity, one stop bit. Each bit is oversampled `prescale` times, and the block raises `data_valid`, `parity_error` or `framing_error` once per completed frame. It sits between the pin-side synchronizer and the command/ALU front end of the system.

## Interface
- DATA_WIDTH, 8, payload bits per frame
- PRESCALE_WIDTH, 6, width of the `prescale` input
- clk  input  1  system clock, all logic rising-edge
- reset  input  1  synchronous, active-low; clears all state and outputs
- prescale  input  PRESCALE_WIDTH  clock cycles per bit; legal values 8, 16, 32
- parity_enable  input  1  1 = parity bit present after data
- parity_type  input  1  0 = even (parity bit = ^data), 1 = odd (parity bit = ~^data)
- serial_data_in  input  1  line input, already synchronous to `clk`, idle high
- parallel_data  output  DATA_WIDTH  last correctly received payload; held until the next good frame
- data_valid  output  1  one-cycle pulse: good frame, `parallel_data` updated this cycle
- parity_error  output  1  one-cycle pulse: parity mismatch, frame discarded
- framing_error  output  1  one-cycle pulse: stop bit sampled 0, frame discarded
- busy  output  1  high while state is not IDLE

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE → START when `serial_data_in`==0. That cycle counts as edge_count 0 of the start bit.
- On that same cycle, latch the configuration:
  - `prescale` (values other than 8/16/32 coerced to 8)
  - `parity_enable`
  - `parity_type`
- edge_count runs 0..P-1 per bit, where P is the latched prescale. bit_count tracks position within the frame.
- Bit sampling:
  - Samples taken at edge_count P/2-1, P/2, P/2+1.
  - Bit value is the majority of the three; it is resolved in the cycle after the P/2+1 sample.
- START:
  - If the resolved bit is 1, treat it as a glitch: return to IDLE with no output pulse.
  - Otherwise go to DATA at edge_count P-1.
- DATA: shift DATA_WIDTH bits LSB-first. After the last bit, go to PARITY if parity is enabled, else to STOP.
- PARITY: compare the resolved bit against the parity computed from the shifted data using the latched parity_type.
- STOP: on resolution, return to IDLE immediately; do not wait out the rest of the stop bit. This allows a start edge within the remaining half-bit.
- Exactly one of the following per frame that passes START:
  - stop=1 and no parity mismatch → `data_valid`, `parallel_data` updated.
  - stop=0 → `framing_error` (takes priority; parity_error not raised).
  - stop=1 with parity mismatch → `parity_error`.
- Input changes to `prescale` and parity controls mid-frame are ignored.

## Timing
- Reset values:
  - `parallel_data` = 0
  - `data_valid` = 0, `parity_error` = 0, `framing_error` = 0
  - `busy` = 0
  - state IDLE, counters 0
- Frame length N = DATA_WIDTH+2 (+1 if parity enabled).
- If t0 is the IDLE cycle that detects the low:
  - bit k majority resolves in cycle t0+k·P+P/2+2.
  - The result pulse is registered high in cycle t0+(N-1)·P+P/2+3 and lasts exactly one cycle.
- `busy` is high from t0+1 through the cycle before the result pulse, and low in the pulse cycle.
- A new start low seen in the pulse cycle or later begins a new frame. Back-to-back frames lose no data.
- Reset asserted mid-frame:
  - Abort to IDLE next edge.
  - No pulses are emitted.
  - `parallel_data` clears to 0.
- Line held low permanently: a framing_error per frame period, then repeated frames while the line stays low.

## Configuration
- `UART_RX_MAJORITY_VOTE_EN` defined: 3-sample majority as above.
- Not defined:
  - Single sample at edge_count P/2; the bit resolves the next cycle.
  - All resolution and pulse times shift 1 cycle earlier.
  - Interface unchanged.

## Structure
- Shared package `uart_pkg`:
  - state encoding localparams (IDLE..STOP)
  - legal prescale constants (8/16/32)
  - DATA_WIDTH default
- One sub-module `uart_rx_sampler`:
  - owns edge_count, the three sample registers / majority (or single sample)
  - emits `bit_value` and a one-cycle `bit_ready` strobe
- The FSM, shift register, parity check and outputs stay in the top.

## Test plan
- P=8, parity_enable=1, type=0, send 0xE6 (parity 1, stop 1) → one `data_valid`, `parallel_data`=0xE6, no errors, at the Timing-derived cycle.
- P=16, parity_enable=1, type=1, send 0xFF with parity bit 0 → `parity_error` pulse, `data_valid` stays 0, `parallel_data` keeps previous 0xE6.
- P=32, parity disabled, send 0xF4 with stop bit 0 → `framing_error` only; next good 0xF4 frame → `data_valid`, 0xF4.
- P=16: line low for 3 cycles then high → no pulses, `busy` back to 0 before edge_count 15.
- P=8, two frames 0x55 then 0xAA back-to-back (second start begins right after the first stop bit) → two `data_valid` pulses exactly N·8 cycles apart, with data 0x55 then 0xAA.
- Reset low during DATA bit 4 → next cycle all outputs 0, state IDLE; subsequent frame 0x3C received correctly.
